// File: rtl/comparador_serial_der_izq.sv
// Bit-serial LSB-first unsigned comparator: done is high WIDTH+1 cycles after an accepted start, and start is ignored while busy.
// The optional registered agb/alb/aeb outputs are enabled with the macro COMPARADOR_FLAGS_EN.
module comparador_serial_der_izq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             z,
   input  logic             y,
   output logic             busy,
   output logic             done,
   output logic             f
`ifdef COMPARADOR_FLAGS_EN
   ,
   output logic             agb,
   output logic             alb,
   output logic             aeb
`endif
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [CW-1:0]    r_cnt;
   logic [1:0]       r_sel;
   logic             r_gt;
   logic             r_eq;
   logic             r_f;
`ifdef COMPARADOR_FLAGS_EN
   logic             r_agb;
   logic             r_alb;
   logic             r_aeb;
`endif

   logic w_diff;
   logic w_gt_nxt;
   logic w_eq_nxt;
   logic w_lt_nxt;
   logic w_last;
   logic w_f_nxt;

   // The last bit pair is folded in combinationally so f is already valid in the DONE cycle.
   assign w_diff   = r_sa[0] ^ r_sb[0];
   assign w_gt_nxt = w_diff ? r_sa[0] : r_gt;
   assign w_eq_nxt = r_eq & ~w_diff;
   assign w_lt_nxt = ~w_gt_nxt & ~w_eq_nxt;
   assign w_last   = (r_state == SHIFT) && (r_cnt == LAST);

   always_comb begin
      w_f_nxt = 1'b0;
      case (r_sel)
         2'b00:   w_f_nxt = w_eq_nxt;
         2'b01:   w_f_nxt = w_gt_nxt;
         2'b10:   w_f_nxt = w_lt_nxt;
         default: w_f_nxt = ~w_eq_nxt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = SHIFT;
         SHIFT:   if (r_cnt == LAST) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sa  <= '0;
         r_sb  <= '0;
         r_cnt <= '0;
         r_sel <= 2'b00;
         r_gt  <= 1'b0;
         r_eq  <= 1'b0;
         r_f   <= 1'b0;
      end else begin
         if (r_state == IDLE && start) begin
            r_sa  <= A;
            r_sb  <= B;
            r_sel <= {z, y};
            r_gt  <= 1'b0;
            r_eq  <= 1'b1;
            r_cnt <= '0;
         end else if (r_state == SHIFT) begin
            r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
            r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
            r_gt  <= w_gt_nxt;
            r_eq  <= w_eq_nxt;
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_last) r_f <= w_f_nxt;
      end
   end

`ifdef COMPARADOR_FLAGS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_agb <= 1'b0;
         r_alb <= 1'b0;
         r_aeb <= 1'b0;
      end else if (w_last) begin
         r_agb <= w_gt_nxt;
         r_alb <= w_lt_nxt;
         r_aeb <= w_eq_nxt;
      end
   end

   assign agb = r_agb;
   assign alb = r_alb;
   assign aeb = r_aeb;
`endif

   assign busy = (r_state != IDLE);
   assign done = (r_state == DONE);
   assign f    = r_f;

endmodule

// File: tb/tb_comparador_serial_der_izq.sv
// Directed bench for the bit-serial comparator: vector table plus reset, handshake and input-hold sequences.
module tb_comparador_serial_der_izq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] A, B;
   logic        z, y;
   logic        busy, done, f;
`ifdef COMPARADOR_FLAGS_EN
   logic        agb, alb, aeb;
`endif

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   comparador_serial_der_izq #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .z(z), .y(y),
      .busy(busy), .done(done), .f(f)
`ifdef COMPARADOR_FLAGS_EN
      , .agb(agb), .alb(alb), .aeb(aeb)
`endif
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  sel;
      logic        exp_f;
      logic [2:0]  exp_flags;   // {agb, alb, aeb}
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // mode 0: plain, 1: scramble inputs after acceptance, 2: extra start pulses at cycles 3, 16, 17
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] sel,
                        input logic exp_f, input logic [2:0] exp_flags, input int mode, input string tag);
      int  n;
      bit  seen;
      @(negedge clk);
      A = a; B = b; {z, y} = sel; start = 1'b1;
      n = 0; seen = 0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 1) chk({tag, " busy_after_start"}, busy, 1);
         if (done) seen = 1;
         if (mode == 1) begin
            A = 16'($urandom); B = 16'($urandom); z = 1'($urandom); y = 1'($urandom);
            start = 1'b0;
         end else if (mode == 2) begin
            start = (n == 3 || n == 16 || n == 17);
            A = 16'h0000; B = 16'hFFFF; {z, y} = 2'b00;
         end else begin
            start = 1'b0;
         end
      end
      chk({tag, " done_seen"}, 32'(seen), 1);
      chk({tag, " latency"}, n, 17);
      chk({tag, " f"}, f, exp_f);
      chk({tag, " busy_in_done"}, busy, 1);
`ifdef COMPARADOR_FLAGS_EN
      chk({tag, " flags"}, {agb, alb, aeb}, exp_flags);
`endif
      @(negedge clk);
      start = 1'b0;
      chk({tag, " done_one_cycle"}, done, 0);
      chk({tag, " idle_after_done"}, busy, 0);
      @(negedge clk);
      chk({tag, " still_idle"}, busy, 0);
      chk({tag, " f_hold"}, f, exp_f);
   endtask

   initial begin
      int n, d1, d2, ndone;
      vecs[0]  = '{16'h8000, 16'h7FFF, 2'b01, 1'b1, 3'b100};
      vecs[1]  = '{16'h8000, 16'h7FFF, 2'b10, 1'b0, 3'b100};
      vecs[2]  = '{16'h0001, 16'h0000, 2'b11, 1'b1, 3'b100};
      vecs[3]  = '{16'h0001, 16'h0000, 2'b00, 1'b0, 3'b100};
      vecs[4]  = '{16'hFFFF, 16'hFFFF, 2'b00, 1'b1, 3'b001};
      vecs[5]  = '{16'h0000, 16'hFFFF, 2'b10, 1'b1, 3'b010};
      vecs[6]  = '{16'h1234, 16'h1235, 2'b01, 1'b0, 3'b010};
      vecs[7]  = '{16'h5A5A, 16'hA5A5, 2'b10, 1'b1, 3'b010};
      vecs[8]  = '{16'h00FF, 16'h0F0F, 2'b11, 1'b1, 3'b010};
      vecs[9]  = '{16'h0F0F, 16'h00FF, 2'b01, 1'b1, 3'b100};
      vecs[10] = '{16'hFFFF, 16'hFFFE, 2'b10, 1'b0, 3'b100};
      vecs[11] = '{16'h1234, 16'h1234, 2'b11, 1'b0, 3'b001};

      rst = 1'b1; start = 1'b0; A = '0; B = '0; z = 1'b0; y = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset f", f, 0);
`ifdef COMPARADOR_FLAGS_EN
      chk("reset flags", {agb, alb, aeb}, 3'b000);
`endif
      rst = 1'b0;

      for (int i = 0; i < 12; i++)
         do_op(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp_f, vecs[i].exp_flags, 0,
               $sformatf("vec%0d", i));

      // Reset at SHIFT cycle 5 after a result of f=1 is on the output.
      do_op(16'hFFFF, 16'hFFFF, 2'b00, 1'b1, 3'b001, 0, "pre_reset");
      @(negedge clk);
      A = 16'h1234; B = 16'h1234; {z, y} = 2'b00; start = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst busy", busy, 0);
      chk("midrst done", done, 0);
      chk("midrst f", f, 0);
      ndone = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk("midrst no_done", ndone, 0);
      chk("midrst f_after", f, 0);
      do_op(16'h1234, 16'h1234, 2'b00, 1'b1, 3'b001, 0, "post_reset");

      // Extra start pulses during SHIFT and DONE are ignored.
      do_op(16'h8000, 16'h7FFF, 2'b01, 1'b1, 3'b100, 2, "ignore_start");

      // Inputs scrambled every cycle after acceptance.
      do_op(16'h00FF, 16'h0F0F, 2'b01, 1'b0, 3'b010, 1, "input_hold");

      // start held high: results every 18 cycles.
      @(negedge clk);
      A = 16'h0000; B = 16'hFFFF; {z, y} = 2'b10; start = 1'b1;
      n = 0; d1 = 0; d2 = 0;
      while (d2 == 0 && n < 60) begin
         @(negedge clk);
         n++;
         if (done) begin
            if (d1 == 0) d1 = n;
            else d2 = n;
         end
         if (d2 != 0) start = 1'b0;
      end
      chk("b2b first_done", d1, 17);
      chk("b2b second_done", d2, 35);
      chk("b2b f", f, 1);
      repeat (2) @(negedge clk);
      chk("b2b idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/comparador_serial_der_izq.md
Name: comparador_serial_der_izq

Overview:
- Bit-serial, sequential counterpart of the combinational left-to-right iterative comparator.
- Processes operands right to left, LSB first: one bit pair per clock through a single reusable cell.
- Produces the same function-selected result f for unsigned A, B under control inputs z, y.
- Used where area matters more than latency; start/busy/done handshake toward the controlling logic.

Parameters:
WIDTH, 16, operand width in bits (>= 2)

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only in IDLE
A  input  WIDTH  operand A, unsigned; captured on accepted start
B  input  WIDTH  operand B, unsigned; captured on accepted start
z  input  1  function select MSB; captured on accepted start
y  input  1  function select LSB; captured on accepted start
busy  output  1  high from cycle after accepted start through the DONE cycle
done  output  1  one-cycle pulse; f valid from this cycle
f  output  1  registered result; holds until next done

Behaviour:
- Reset: synchronous, active-high. On the clk edge where rst=1: state=IDLE, busy=0, done=0, f=0, counter=0, internal flags cleared. rst overrides start and any in-progress operation; a partial result is discarded, no done pulse.
- Function select, latched (z,y):
  - 00: f = (A==B)
  - 01: f = (A>B)
  - 10: f = (A<B)
  - 11: f = (A!=B)
- Internal state: shift registers sa, sb (WIDTH); flags gt, eq; counter cnt of width clog2(WIDTH)+1; latched sel[1:0].
- IDLE:
  - busy=0, done=0.
  - start=1 -> load sa=A, sb=B, sel={z,y}, gt=0, eq=1, cnt=0; go to SHIFT.
  - start=0 -> stay in IDLE.
- SHIFT, one bit pair per cycle, examining sa[0] and sb[0]:
  - If sa[0]!=sb[0]: gt<=sa[0], eq<=0. Later (more significant) bits override earlier ones, which gives correct unsigned ordering LSB-first.
  - If the bits are equal: gt and eq unchanged.
  - sa, sb shift right by 1; cnt increments.
  - When cnt==WIDTH-1 (last bit processed), go to DONE.
  - No early termination.
- DONE:
  - f <= function of final gt/eq/sel, with lt = !gt & !eq.
  - done=1 for exactly this cycle; busy still 1.
  - Next state IDLE.
- Latency: start accepted at edge 0 -> WIDTH SHIFT cycles -> done high in cycle WIDTH+1. For WIDTH=16, done follows 17 cycles after the accepting edge. Throughput is one result per WIDTH+2 cycles.
- start while busy=1, including in the DONE cycle, is ignored; it is not queued.
- start held high continuously -> new operation accepted in the first IDLE cycle after done.
- A, B, z, y may change freely after acceptance; the latched copies are used.
- f is stable between done pulses; f=0 after reset until the first done.

Optional Feature:
- Macro: COMPARADOR_FLAGS_EN.
- Defined: adds outputs agb, alb, aeb, each 1 bit and registered.
  - Updated in the DONE cycle alongside f: agb=gt, alb=lt, aeb=eq.
  - Exactly one is 1 after any completion.
  - All three reset to 0 and hold between operations.
- Undefined: ports and registers absent; f behaviour identical.

Test Plan:
- Reset mid-operation: start with A=16'h1234, B=16'h1234, sel=00; assert rst at SHIFT cycle 5 -> busy=0, done never pulses, f=0. Then a new start completes normally with f=1 at cycle 17.
- MSB-dominates ordering: A=16'h8000, B=16'h7FFF, sel=01 -> done at cycle 17, f=1. Same operands with sel=10 -> f=0.
- LSB-only difference: A=16'h0001, B=16'h0000, sel=11 -> f=1. Same operands with sel=00 -> f=0. With COMPARADOR_FLAGS_EN: agb=1, alb=0, aeb=0.
- Extremes: A=16'hFFFF, B=16'hFFFF, sel=00 -> f=1. A=16'h0000, B=16'hFFFF, sel=10 -> f=1.
- Handshake: start pulsed again at SHIFT cycles 3 and 16 with different operands -> ignored; single done; f reflects first operands. start held high -> back-to-back results every 18 cycles.
- Input hold: change A, B, z, y every cycle after acceptance of A=16'h00FF, B=16'h0F0F, sel=01 -> f=0 (0x00FF < 0x0F0F).
